// File: rtl/eth_udp_pkg.sv
// Shared constants and FSM state encoding for the UDP/IPv4 GMII transmit path.
package eth_udp_pkg;

    localparam int unsigned CNT_W           = 11;
    localparam int unsigned MAX_UDP_PAYLOAD = 1472;
    localparam int unsigned MIN_PAYLOAD     = 18;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned ETH_HDR_LEN  = 14;
    localparam int unsigned IP_HDR_LEN   = 20;
    localparam int unsigned UDP_HDR_LEN  = 8;
    localparam int unsigned FCS_LEN      = 4;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_FLAGS_FRAG  = 16'h4000;  // DF set, offset 0
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_PREAMBLE = 4'd1;
    localparam state_t ST_ETH      = 4'd2;
    localparam state_t ST_IP       = 4'd3;
    localparam state_t ST_UDP      = 4'd4;
    localparam state_t ST_DATA     = 4'd5;
    localparam state_t ST_PAD      = 4'd6;
    localparam state_t ST_FCS      = 4'd7;
    localparam state_t ST_IFG      = 4'd8;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 (reflected form of poly 04C11DB7) with clear and
// enable; the raw register is exposed, the caller inverts it for the FCS.
module crc32_d8 (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] work_c;

    always_comb begin
        crc_d  = crc_q;
        work_c = crc_q ^ {24'h0, din};
        for (int i = 0; i < 8; i++) begin
            work_c = work_c[0] ? ((work_c >> 1) ^ POLY_REFL) : (work_c >> 1);
        end
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = work_c;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/udp_ip_tx_framer.sv
// GMII UDP/IPv4 transmit framer: preamble, Ethernet/IP/UDP headers, FIFO payload,
// zero padding and FCS. state_q/cnt_q name the byte that appears on GMII next cycle.
module udp_ip_tx_framer
    import eth_udp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h00_0a_35_01_fe_c0,
    parameter logic [31:0] LOCAL_IP   = 32'hc0_a8_00_02,
    parameter logic [15:0] LOCAL_PORT = 16'd5000,
    parameter logic [7:0]  IP_TTL     = 8'd64,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        tx_start,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    input  logic [15:0] dst_port,
    input  logic [15:0] data_len,
    output logic        payload_req,
    input  logic [7:0]  payload_dat,
    output logic        cal_en,
    output logic [15:0] ip_total_len,
    output logic [15:0] ip_id,
    input  logic [15:0] ip_checksum,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        busy,
    output logic        tx_done,
    output logic        len_err
);

    state_t             state_q, state_d, next_state_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d, last_cnt_c;
    logic               at_last_c, short_c;
    logic [47:0]        dst_mac_q, dst_mac_d;
    logic [31:0]        dst_ip_q, dst_ip_d;
    logic [15:0]        dst_port_q, dst_port_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        csum_q, csum_d;
    logic [15:0]        ip_id_q, ip_id_d;
    logic [15:0]        total_len_q, total_len_d;
    logic               cal_en_q, cal_en_d, req_q, req_d, tx_en_q, tx_en_d;
    logic               busy_q, busy_d, done_q, done_d, len_err_q, len_err_d;
    logic [7:0]         txd_q, txd_d;
    logic               crc_clr_c, crc_en_c;
    logic [31:0]        crc_val, fcs_c;
    logic [13:0][7:0]   eth_hdr_c;
    logic [19:0][7:0]   ip_hdr_c;
    logic [7:0][7:0]    udp_hdr_c;

    assign eth_hdr_c = {dst_mac_q, LOCAL_MAC, ETHERTYPE_IPV4};
    assign ip_hdr_c  = {IP_VER_IHL, 8'h00, total_len_q, ip_id_q, IP_FLAGS_FRAG,
                        IP_TTL, IP_PROTO_UDP, csum_q, LOCAL_IP, dst_ip_q};
    assign udp_hdr_c = {LOCAL_PORT, dst_port_q, len_q + 16'd8, 16'h0000};
    assign short_c   = (len_q < 16'(MIN_PAYLOAD));
    assign fcs_c     = ~crc_val;

    // Length of the current section and where it leads.
    always_comb begin
        last_cnt_c   = '0;
        next_state_c = ST_IDLE;
        case (state_q)
            ST_PREAMBLE: begin last_cnt_c = CNT_W'(PREAMBLE_LEN - 1); next_state_c = ST_ETH; end
            ST_ETH:      begin last_cnt_c = CNT_W'(ETH_HDR_LEN - 1);  next_state_c = ST_IP;  end
            ST_IP:       begin last_cnt_c = CNT_W'(IP_HDR_LEN - 1);   next_state_c = ST_UDP; end
            ST_UDP: begin
                last_cnt_c   = CNT_W'(UDP_HDR_LEN - 1);
                next_state_c = (len_q == 16'd0) ? ST_PAD : ST_DATA;
            end
            ST_DATA: begin
                last_cnt_c   = len_q[CNT_W-1:0] - CNT_W'(1);
                next_state_c = short_c ? ST_PAD : ST_FCS;
            end
            ST_PAD: begin
                last_cnt_c   = CNT_W'(MIN_PAYLOAD - 1) - len_q[CNT_W-1:0];
                next_state_c = ST_FCS;
            end
            ST_FCS:      begin last_cnt_c = CNT_W'(FCS_LEN - 1); next_state_c = ST_IFG; end
            // One extra IFG state covers the output register lag so tx_en is low IFG_CYCLES cycles.
            ST_IFG:      begin last_cnt_c = CNT_W'(IFG_CYCLES);  next_state_c = ST_IDLE; end
            default: ;
        endcase
    end

    assign at_last_c = (cnt_q == last_cnt_c);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_mac_d   = dst_mac_q;
        dst_ip_d    = dst_ip_q;
        dst_port_d  = dst_port_q;
        len_d       = len_q;
        total_len_d = total_len_q;
        csum_d      = csum_q;
        cal_en_d    = 1'b0;
        len_err_d   = 1'b0;
        tx_en_d     = 1'b0;
        txd_d       = 8'h00;
        crc_clr_c   = 1'b0;
        crc_en_c    = 1'b0;

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (tx_start) begin
                if (data_len <= 16'(MAX_UDP_PAYLOAD)) begin
                    state_d     = ST_PREAMBLE;
                    cal_en_d    = 1'b1;
                    dst_mac_d   = dst_mac;
                    dst_ip_d    = dst_ip;
                    dst_port_d  = dst_port;
                    len_d       = data_len;
                    total_len_d = data_len + 16'd28;
                end else begin
                    len_err_d = 1'b1;
                end
            end
        end else begin
            cnt_d = at_last_c ? '0 : cnt_q + CNT_W'(1);
            if (at_last_c) begin
                state_d = next_state_c;
            end
        end

        case (state_q)
            ST_PREAMBLE: begin
                tx_en_d   = 1'b1;
                txd_d     = at_last_c ? SFD_BYTE : PREAMBLE_BYTE;
                crc_clr_c = 1'b1;
                if (cnt_q == CNT_W'(2)) begin
                    csum_d = ip_checksum;
                end
            end
            ST_ETH:  begin tx_en_d = 1'b1; crc_en_c = 1'b1; txd_d = eth_hdr_c[4'(CNT_W'(ETH_HDR_LEN - 1) - cnt_q)]; end
            ST_IP:   begin tx_en_d = 1'b1; crc_en_c = 1'b1; txd_d = ip_hdr_c[5'(CNT_W'(IP_HDR_LEN - 1) - cnt_q)]; end
            ST_UDP:  begin tx_en_d = 1'b1; crc_en_c = 1'b1; txd_d = udp_hdr_c[3'(CNT_W'(UDP_HDR_LEN - 1) - cnt_q)]; end
            ST_DATA: begin tx_en_d = 1'b1; crc_en_c = 1'b1; txd_d = payload_dat; end
            ST_PAD:  begin tx_en_d = 1'b1; crc_en_c = 1'b1; end
            ST_FCS:  begin tx_en_d = 1'b1; txd_d = fcs_c[{cnt_q[1:0], 3'b000} +: 8]; end
            default: ;
        endcase
    end

    // FIFO data lands one cycle after the strobe, so the strobe leads the DATA section by one.
    assign req_d = ((state_d == ST_UDP) && (cnt_d == CNT_W'(UDP_HDR_LEN - 1)) && (len_q != 16'd0))
                || ((state_d == ST_DATA) && (cnt_d != len_q[CNT_W-1:0] - CNT_W'(1)));
    assign busy_d  = (state_d != ST_IDLE);
    assign done_d  = (state_q == ST_FCS) && at_last_c;
    assign ip_id_d = done_d ? ip_id_q + 16'd1 : ip_id_q;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dst_mac_q   <= '0;
            dst_ip_q    <= '0;
            dst_port_q  <= '0;
            len_q       <= '0;
            total_len_q <= '0;
            csum_q      <= '0;
            ip_id_q     <= '0;
            cal_en_q    <= 1'b0;
            req_q       <= 1'b0;
            tx_en_q     <= 1'b0;
            txd_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_mac_q   <= dst_mac_d;
            dst_ip_q    <= dst_ip_d;
            dst_port_q  <= dst_port_d;
            len_q       <= len_d;
            total_len_q <= total_len_d;
            csum_q      <= csum_d;
            ip_id_q     <= ip_id_d;
            cal_en_q    <= cal_en_d;
            req_q       <= req_d;
            tx_en_q     <= tx_en_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
        end
    end

    crc32_d8 u_crc (
        .clk     (clk),
        .reset_p (reset_p),
        .clr     (crc_clr_c),
        .en      (crc_en_c),
        .din     (txd_d),
        .crc     (crc_val)
    );

    assign payload_req  = req_q;
    assign cal_en       = cal_en_q;
    assign ip_total_len = total_len_q;
    assign ip_id        = ip_id_q;
    assign gmii_tx_en   = tx_en_q;
    assign gmii_txd     = txd_q;
    assign busy         = busy_q;
    assign tx_done      = done_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_udp_ip_tx_framer.sv
// Bench for udp_ip_tx_framer: byte FIFO and ip_checksum neighbour models, and a
// frame reference built from the header/CRC rules with queues and arithmetic.
module tb_udp_ip_tx_framer;

    localparam logic [47:0] LOCAL_MAC  = 48'h00_0a_35_01_fe_c0;
    localparam logic [31:0] LOCAL_IP   = 32'hc0_a8_00_02;
    localparam logic [15:0] LOCAL_PORT = 16'd5000;
    localparam logic [7:0]  IP_TTL     = 8'd64;
    localparam int          IFG        = 12;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        tx_start;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [15:0] data_len;
    logic        payload_req;
    logic [7:0]  payload_dat = 8'h00;
    logic        cal_en;
    logic [15:0] ip_total_len;
    logic [15:0] ip_id;
    logic [15:0] csum_in = 16'h0000;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        busy;
    logic        tx_done;
    logic        len_err;

    always #4 clk = ~clk;

    udp_ip_tx_framer #(
        .LOCAL_MAC  (LOCAL_MAC),
        .LOCAL_IP   (LOCAL_IP),
        .LOCAL_PORT (LOCAL_PORT),
        .IP_TTL     (IP_TTL),
        .IFG_CYCLES (IFG)
    ) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .tx_start     (tx_start),
        .dst_mac      (dst_mac),
        .dst_ip       (dst_ip),
        .dst_port     (dst_port),
        .data_len     (data_len),
        .payload_req  (payload_req),
        .payload_dat  (payload_dat),
        .cal_en       (cal_en),
        .ip_total_len (ip_total_len),
        .ip_id        (ip_id),
        .ip_checksum  (csum_in),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_txd     (gmii_txd),
        .busy         (busy),
        .tx_done      (tx_done),
        .len_err      (len_err)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  body_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] cur_dst_ip = 32'h0;
    logic [15:0] next_id = 16'd0;

    function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id,
                                            input logic [31:0] dip);
        int unsigned s;
        s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'({IP_TTL, 8'd17})
          + 32'(LOCAL_IP[31:16]) + 32'(LOCAL_IP[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic logic [31:0] crc32_of_body();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (body_q[i]) begin
            c = c ^ {24'h0, body_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [7:0] byte_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 8'hxx;
    endfunction

    // ip_checksum neighbour: result valid the cycle after cal_en and held.
    always @(posedge clk) if (cal_en) csum_in <= ip_csum(ip_total_len, ip_id, cur_dst_ip);

    // Upstream byte FIFO: data valid the cycle after each read strobe.
    always @(posedge clk) begin
        if (payload_req) payload_dat <= (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hEE;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) body_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build_expected(input logic [47:0] mac, input logic [31:0] dip,
                                  input logic [15:0] dport, input int len, input logic [15:0] id,
                                  input logic [7:0] pl[$]);
        logic [31:0] fcs;
        body_q.delete();
        exp_q.delete();
        push_be(mac, 6);
        push_be(LOCAL_MAC, 6);
        push_be(48'h0800, 2);
        push_be(48'h4500, 2);
        push_be(48'(len + 28), 2);
        push_be(48'(id), 2);
        push_be(48'h4000, 2);
        push_be(48'({IP_TTL, 8'd17}), 2);
        push_be(48'(ip_csum(16'(len + 28), id, dip)), 2);
        push_be(48'(LOCAL_IP), 4);
        push_be(48'(dip), 4);
        push_be(48'(LOCAL_PORT), 2);
        push_be(48'(dport), 2);
        push_be(48'(len + 8), 2);
        push_be(48'h0, 2);
        foreach (pl[i]) body_q.push_back(pl[i]);
        while (body_q.size() < 42 + 18) body_q.push_back(8'h00);
        fcs = crc32_of_body();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body_q[i]) exp_q.push_back(body_q[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    task automatic run_frame(input logic [47:0] mac, input logic [31:0] dip, input logic [15:0] dport,
                             input int len, input bit seq_pl, input int exp_cycles,
                             input int exp_udp_len, input int exp_tl, input bit poke_ifg);
        logic [7:0]  pl[$];
        logic [15:0] tl_seen, id_seen;
        int cal_cnt, req_cnt, done_cnt, done_at, segs, busy_after, cyc, nmis;
        bit prev_en, seen_done, finished;
        string tag;
        tag = $sformatf("len%0d_id%0d", len, next_id);
        cal_cnt = 0; req_cnt = 0; done_cnt = 0; done_at = -1; segs = 0; busy_after = 0;
        cyc = 0; prev_en = 0; seen_done = 0; finished = 0; tl_seen = '0; id_seen = '0;
        for (int i = 0; i < len; i++) pl.push_back(seq_pl ? 8'(i) : 8'($urandom_range(0, 255)));
        fifo_q = pl;
        got_q.delete();
        build_expected(mac, dip, dport, len, next_id, pl);
        cur_dst_ip = dip;
        @(negedge clk);
        dst_mac = mac; dst_ip = dip; dst_port = dport; data_len = 16'(len); tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        while (!finished && cyc < len + 400) begin
            if (cal_en) begin cal_cnt++; tl_seen = ip_total_len; id_seen = ip_id; end
            if (payload_req) req_cnt++;
            if (gmii_tx_en) begin got_q.push_back(gmii_txd); if (!prev_en) segs++; end
            prev_en = gmii_tx_en;
            if (tx_done) begin done_cnt++; done_at = got_q.size(); seen_done = 1; end
            else if (seen_done) begin
                if (busy) busy_after++; else finished = 1;
            end
            tx_start = poke_ifg && seen_done && busy && (busy_after == 3);
            if (tx_start) data_len = 16'd10;
            @(negedge clk);
            cyc++;
        end
        tx_start = 1'b0;
        check({tag, "_completed_in_budget"}, 64'(finished), 64'd1);
        check({tag, "_cal_en_pulses"}, 64'(cal_cnt), 64'd1);
        check({tag, "_ip_total_len"}, 64'(tl_seen), 64'(exp_tl));
        check({tag, "_ip_id"}, 64'(id_seen), 64'(next_id));
        check({tag, "_tx_en_cycles"}, 64'(got_q.size()), 64'(exp_cycles));
        check({tag, "_tx_en_segments"}, 64'(segs), 64'd1);
        check({tag, "_tx_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_tx_done_on_last_byte"}, 64'(done_at), 64'(exp_cycles));
        check({tag, "_busy_after_done"}, 64'(busy_after), 64'(IFG));
        check({tag, "_fifo_reads"}, 64'(req_cnt), 64'(len));
        check({tag, "_ip_checksum_field"}, 64'({byte_at(32), byte_at(33)}),
              64'(ip_csum(16'(exp_tl), next_id, dip)));
        check({tag, "_udp_len_field"}, 64'({byte_at(46), byte_at(47)}), 64'(exp_udp_len));
        nmis = 0;
        foreach (exp_q[i]) if (byte_at(i) !== exp_q[i]) nmis++;
        check({tag, "_frame_bytes_wrong"}, 64'(nmis), 64'd0);
        next_id = next_id + 16'd1;
    endtask

    typedef struct {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] port;
        int          len;
        bit          seq;
        int          exp_cycles;
        int          exp_udp_len;
        int          exp_tl;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, cyc, cnt_en, cnt_cal, cnt_busy, cnt_err, len;
        vecs[0] = '{48'h02_11_22_33_44_55, 32'hc0a80003, 16'd6000, 18,   1'b1, 72,   26,   46};
        vecs[1] = '{48'h02_11_22_33_44_55, 32'hc0a80003, 16'd6000, 5,    1'b0, 72,   13,   33};
        vecs[2] = '{48'hff_ff_ff_ff_ff_ff, 32'h0a000001, 16'd53,   0,    1'b0, 72,   8,    28};
        vecs[3] = '{48'h00_1b_21_aa_bb_cc, 32'hc0a80064, 16'd9,    17,   1'b0, 72,   25,   45};
        vecs[4] = '{48'h00_1b_21_aa_bb_cc, 32'hc0a80064, 16'd4321, 19,   1'b0, 73,   27,   47};
        vecs[5] = '{48'h3c_97_0e_12_34_56, 32'hac100001, 16'd65535, 1472, 1'b0, 1526, 1480, 1500};

        reset_p = 1'b1; tx_start = 1'b0; dst_mac = '0; dst_ip = '0; dst_port = '0; data_len = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_en", 64'(gmii_tx_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_outputs", 64'({payload_req, cal_en, tx_done, len_err, gmii_txd}), 64'd0);
        check("reset_ip_id", 64'(ip_id), 64'd0);
        check("reset_ip_total_len", 64'(ip_total_len), 64'd0);
        reset_p = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of DATA abandons the frame without bumping the IP id.
        fifo_q.delete();
        for (int i = 0; i < 40; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
        cur_dst_ip = 32'hc0a80009;
        dst_mac = 48'h02_00_00_00_00_09; dst_ip = 32'hc0a80009; dst_port = 16'd7000;
        data_len = 16'd40; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n = 0; cyc = 0;
        while (n < 55 && cyc < 200) begin
            if (gmii_tx_en) n++;
            @(negedge clk);
            cyc++;
        end
        check("rstmid_reached_data", 64'(n), 64'd55);
        check("rstmid_tx_en_before", 64'(gmii_tx_en), 64'd1);
        #1 reset_p = 1'b1;
        #1;
        check("rstmid_tx_en_async_drop", 64'(gmii_tx_en), 64'd0);
        check("rstmid_busy_drop", 64'(busy), 64'd0);
        @(negedge clk);
        reset_p = 1'b0;
        fifo_q.delete();
        repeat (3) @(negedge clk);
        check("rstmid_ip_id_unchanged", 64'(ip_id), 64'(next_id));
        check("rstmid_idle_tx_en", 64'(gmii_tx_en), 64'd0);

        foreach (vecs[i])
            run_frame(vecs[i].mac, vecs[i].ip, vecs[i].port, vecs[i].len, vecs[i].seq,
                      vecs[i].exp_cycles, vecs[i].exp_udp_len, vecs[i].exp_tl, 1'b0);

        // Oversized payload is rejected with a single len_err pulse.
        @(negedge clk);
        data_len = 16'd1473; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("lenerr_pulse", 64'(len_err), 64'd1);
        check("lenerr_busy", 64'(busy), 64'd0);
        cnt_en = 0; cnt_cal = 0; cnt_busy = 0; cnt_err = 0;
        repeat (20) begin
            @(negedge clk);
            cnt_en += int'(gmii_tx_en); cnt_cal += int'(cal_en);
            cnt_busy += int'(busy); cnt_err += int'(len_err);
        end
        check("lenerr_single_cycle", 64'(cnt_err), 64'd0);
        check("lenerr_no_activity", 64'(cnt_en + cnt_cal + cnt_busy), 64'd0);
        check("lenerr_ip_id", 64'(ip_id), 64'(next_id));

        // A start during the IFG is ignored; the next real start gets a fresh id and checksum.
        run_frame(48'h02_aa_bb_cc_dd_ee, 32'hc0a80003, 16'd6000, 30, 1'b0, 84, 38, 58, 1'b1);
        cnt_en = 0; cnt_cal = 0; cnt_busy = 0;
        repeat (30) begin
            @(negedge clk);
            cnt_en += int'(gmii_tx_en); cnt_cal += int'(cal_en); cnt_busy += int'(busy);
        end
        check("ifg_start_ignored", 64'(cnt_en + cnt_cal + cnt_busy), 64'd0);
        run_frame(48'h02_aa_bb_cc_dd_ee, 32'hc0a80003, 16'd6001, 30, 1'b0, 84, 38, 58, 1'b0);

        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(0, 120));
            run_frame(48'({$urandom(), $urandom()}), $urandom(), 16'($urandom()), len, 1'b0,
                      54 + ((len > 18) ? len : 18), len + 8, len + 28, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/udp_ip_tx_framer.md
Name: udp_ip_tx_framer

Overview:
- GMII transmit framer for the UDP/IP Ethernet path.
- On a start pulse it latches the destination tuple and payload length. It then drives the header fields into the neighbouring ip_checksum stage and captures its checksum.
- It emits preamble/SFD, Ethernet header, IPv4 header, UDP header, payload pulled from the upstream byte FIFO, zero padding and FCS on GMII TXD/TX_EN.
- It sits directly downstream of ip_checksum and upstream of the GMII PHY interface.

Parameters:
LOCAL_MAC, 48'h00_0a_35_01_fe_c0, source MAC placed in Ethernet header
LOCAL_IP, 32'hc0_a8_00_02, source IP (192.168.0.2)
LOCAL_PORT, 16'd5000, UDP source port
IP_TTL, 8'd64, IPv4 time-to-live
IFG_CYCLES, 12, idle cycles enforced after FCS before busy drops

Ports:
clk  in  1  GMII TX clock (125 MHz); all logic on rising edge
reset_p  in  1  asynchronous active-high reset
tx_start  in  1  one-cycle start pulse; honoured only when busy=0
dst_mac  in  48  destination MAC, sampled on accepted tx_start
dst_ip  in  32  destination IP, sampled on accepted tx_start
dst_port  in  16  UDP destination port, sampled on accepted tx_start
data_len  in  16  UDP payload byte count, sampled on accepted tx_start
payload_req  out  1  FIFO read strobe, one byte per asserted cycle
payload_dat  in  8  FIFO read data, valid the cycle after payload_req
cal_en  out  1  checksum calculate enable to ip_checksum
ip_total_len  out  16  to ip_checksum IP_total_len (= data_len+28)
ip_id  out  16  to ip_checksum IP_id
ip_checksum  in  16  checksum result from ip_checksum
gmii_tx_en  out  1  GMII transmit enable
gmii_txd  out  8  GMII transmit data
busy  out  1  high from accepted start until IFG complete
tx_done  out  1  one-cycle pulse on last FCS byte
len_err  out  1  one-cycle pulse when tx_start is rejected for data_len>1472

Behaviour:
- Reset: all outputs 0. ip_id counter=0. FSM=IDLE.
- Fixed fields presented to ip_checksum:
  - ver 4, ihl 5, tos 0
  - flags DF=1, MF=0, rsv=0, frag offset 0
  - ttl IP_TTL, protocol 17
  - src LOCAL_IP, dst latched dst_ip
- Start handling:
  - tx_start accepted in IDLE when data_len<=1472: latch all inputs; busy=1 next cycle; cal_en=1 for exactly one cycle (the cycle after acceptance).
  - ip_checksum is captured on the 3rd cycle of PREAMBLE.
  - tx_start while busy: ignored, no side effects.
  - tx_start with data_len>1472: len_err pulse, stays IDLE.
- FSM and byte counts; all outputs registered:
  - PREAMBLE: 7x 8'h55 then 8'hD5.
  - ETH_HDR (14): dst_mac MSB first, LOCAL_MAC, 16'h0800.
  - IP_HDR (20): standard order, multi-byte fields big-endian; checksum at bytes 10-11.
  - UDP_HDR (8): LOCAL_PORT, dst_port, data_len+8, checksum 16'h0000.
  - DATA: data_len bytes from FIFO.
  - PAD: (18-data_len) bytes of 8'h00 when data_len<18, else skipped.
  - FCS (4): CRC-32 over ETH_HDR..PAD, bit-reflected, inverted, LSB byte first.
  - IFG: IFG_CYCLES cycles with tx_en=0, then IDLE with busy=0.
- gmii_tx_en=1 from the first preamble byte through the last FCS byte, contiguous, no gaps.
- FIFO prefetch: payload_req asserted on the last UDP_HDR byte cycle and on each DATA cycle except the last, so exactly data_len reads occur. The FIFO must hold data_len bytes before tx_start; underflow is not detected.
- data_len=0: DATA skipped, 18 pad bytes, UDP length 8.
- ip_id increments by 1 (wrapping at 16'hFFFF) on each tx_done.
- Frame length: 8 + 42 + max(data_len,18) + 4 = 54 + max(data_len,18) tx_en cycles.
- Reset mid-frame: gmii_tx_en drops asynchronously; FSM returns to IDLE; CRC cleared; partial frame abandoned.

Decomposition:
- Shared package eth_udp_pkg holds:
  - ETHERTYPE_IPV4, IP_PROTO_UDP
  - PREAMBLE_BYTE, SFD_BYTE
  - MAX_UDP_PAYLOAD=1472, MIN_PAYLOAD=18
  - header length constants
  - FSM state typedef
- One sub-module: crc32_d8, a byte-wide CRC-32 (poly 04C11DB7, reflected) with clear/enable inputs and registered output.
- ip_checksum is instantiated at the parent level, not inside this block.

Test Plan:
- Basic frame: dst 192.168.0.3, dst_port 6000, data_len 18 with bytes 0..17.
  - gmii_tx_en high 72 cycles.
  - IP total len 46, UDP len 26, IP id 0.
  - Checksum equals model value.
  - FCS matches software CRC-32.
  - tx_done on cycle 72; busy low 12 cycles later.
- Short payload data_len 5 -> 5 FIFO reads, 13 zero pad bytes, UDP len 13, 72 tx_en cycles.
- data_len 1472 -> 1526 tx_en cycles; data_len 1473 -> len_err pulse, no tx_en, busy stays 0.
- Back-to-back frames: tx_start during the IFG of frame 1 -> ignored; a later start -> second frame with IP id 1 and its checksum recomputed.
- reset_p asserted during the DATA state -> gmii_tx_en=0 immediately; next frame transmits correctly with IP id unchanged.
- cal_en timing: exactly one pulse per accepted start. Checksum bytes at IP bytes 10-11 equal the ip_checksum value for the latched fields.
